// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle for one pipeline boundary register.
// The stage-control side drives the D fields; the register drives the Q fields.
interface pipe_stage_reg_if #(
    parameter int unsigned DW  = 96,
    parameter int unsigned AW  = 5,
    parameter int unsigned TW  = 3,
    parameter int unsigned HCW = 8
);
    logic           en;
    logic           clr;
    logic           req;
    logic           d_valid;
    logic [31:0]    d_pc;
    logic           d_bd;
    logic [AW-1:0]  d_wr;
    logic           d_regwrite;
    logic [TW-1:0]  d_tnew;
    logic [DW-1:0]  d_payload;

    logic           q_valid;
    logic [31:0]    q_pc;
    logic [31:0]    q_pc8;
    logic           q_bd;
    logic [AW-1:0]  q_wr;
    logic           q_regwrite;
    logic [TW-1:0]  q_tnew;
    logic [DW-1:0]  q_payload;
    logic [HCW-1:0] q_hold_cnt;

    modport master (
        output en, clr, req, d_valid, d_pc, d_bd, d_wr, d_regwrite, d_tnew, d_payload,
        input  q_valid, q_pc, q_pc8, q_bd, q_wr, q_regwrite, q_tnew, q_payload, q_hold_cnt
    );

    modport slave (
        input  en, clr, req, d_valid, d_pc, d_bd, d_wr, d_regwrite, d_tnew, d_payload,
        output q_valid, q_pc, q_pc8, q_bd, q_wr, q_regwrite, q_tnew, q_payload, q_hold_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with hold, bubble, exception flush and stall-age count.
// Gated/derived outputs are computed from the next state and registered alongside it.
module pipe_stage_reg #(
    parameter int unsigned    DW                = 96,
    parameter int unsigned    AW                = 5,
    parameter int unsigned    TW                = 3,
    parameter int unsigned    TNEW_DEC          = 1,
    parameter logic [31:0]    PC_RESET          = 32'h0000_3000,
    parameter logic [31:0]    PC_REQ            = 32'h0000_4180,
    parameter bit             KEEP_PC_ON_BUBBLE = 1'b1,
    parameter logic [DW-1:0]  STICKY_MASK       = '0,
    parameter int unsigned    HCW               = 8
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_reg_if.slave  bus
);

    localparam logic [HCW-1:0] HC_MAX  = '1;
    localparam logic [TW-1:0]  DEC     = TW'(TNEW_DEC);
    localparam logic [31:0]    PC_STEP = 32'd8;

    typedef struct packed {
        logic           valid;
        logic [31:0]    pc;
        logic           bd;
        logic [AW-1:0]  wr;
        logic           regwrite;
        logic [TW-1:0]  tnew;
        logic [DW-1:0]  payload;
        logic [HCW-1:0] hold_cnt;
    } stage_t;

    stage_t         st_q;
    stage_t         st_d;
    logic           regwrite_d;
    logic [AW-1:0]  wr_d;
    logic [TW-1:0]  tnew_d;
    logic [31:0]    pc8_d;
    logic           regwrite_q;
    logic [AW-1:0]  wr_q;
    logic [TW-1:0]  tnew_q;
    logic [31:0]    pc8_q;

    // Next-state selection: req > clr > hold > load (reset handled in the flop).
    always_comb begin
        st_d = st_q;
        if (bus.req) begin
            st_d          = '0;
            st_d.pc       = PC_REQ;
        end else if (bus.clr) begin
            st_d.valid    = 1'b0;
            st_d.wr       = '0;
            st_d.regwrite = 1'b0;
            st_d.tnew     = '0;
            st_d.payload  = st_q.payload & STICKY_MASK;
            st_d.pc       = KEEP_PC_ON_BUBBLE ? bus.d_pc : PC_RESET;
            st_d.bd       = KEEP_PC_ON_BUBBLE ? bus.d_bd : 1'b0;
            st_d.hold_cnt = '0;
        end else if (!bus.en) begin
            if (!st_q.valid)
                st_d.hold_cnt = '0;
            else if (st_q.hold_cnt != HC_MAX)
                st_d.hold_cnt = st_q.hold_cnt + HCW'(1);
        end else begin
            st_d.valid    = bus.d_valid;
            st_d.pc       = bus.d_pc;
            st_d.bd       = bus.d_bd;
            st_d.wr       = bus.d_wr;
            st_d.regwrite = bus.d_regwrite;
            st_d.tnew     = bus.d_tnew;
            st_d.payload  = bus.d_payload;
            st_d.hold_cnt = '0;
        end
    end

    // Output views of the next state, so every Q port comes straight from a flop.
    always_comb begin
        regwrite_d = st_d.regwrite & st_d.valid;
        wr_d       = regwrite_d ? st_d.wr : '0;
        tnew_d     = '0;
        if (st_d.valid && (st_d.tnew >= DEC))
            tnew_d = st_d.tnew - DEC;
        pc8_d      = st_d.pc + PC_STEP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= '0;
            st_q.pc    <= PC_RESET;
            regwrite_q <= 1'b0;
            wr_q       <= '0;
            tnew_q     <= '0;
            pc8_q      <= PC_RESET + PC_STEP;
        end else begin
            st_q       <= st_d;
            regwrite_q <= regwrite_d;
            wr_q       <= wr_d;
            tnew_q     <= tnew_d;
            pc8_q      <= pc8_d;
        end
    end

    assign bus.q_valid    = st_q.valid;
    assign bus.q_pc       = st_q.pc;
    assign bus.q_pc8      = pc8_q;
    assign bus.q_bd       = st_q.bd;
    assign bus.q_wr       = wr_q;
    assign bus.q_regwrite = regwrite_q;
    assign bus.q_tnew     = tnew_q;
    assign bus.q_payload  = st_q.payload;
    assign bus.q_hold_cnt = st_q.hold_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (sticky/keep-PC and plain/reset-PC bubbles)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 96;
    localparam int unsigned AW = 5;
    localparam int unsigned TW = 3;
    localparam int unsigned HCW = 8;
    localparam logic [DW-1:0] MASK0 = 96'hF;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DW(DW), .AW(AW), .TW(TW), .HCW(HCW)) if0 ();
    pipe_stage_reg_if #(.DW(DW), .AW(AW), .TW(TW), .HCW(HCW)) if1 ();

    assign if1.en         = if0.en;
    assign if1.clr        = if0.clr;
    assign if1.req        = if0.req;
    assign if1.d_valid    = if0.d_valid;
    assign if1.d_pc       = if0.d_pc;
    assign if1.d_bd       = if0.d_bd;
    assign if1.d_wr       = if0.d_wr;
    assign if1.d_regwrite = if0.d_regwrite;
    assign if1.d_tnew     = if0.d_tnew;
    assign if1.d_payload  = if0.d_payload;

    pipe_stage_reg #(.DW(DW), .AW(AW), .TW(TW), .TNEW_DEC(1), .KEEP_PC_ON_BUBBLE(1'b1),
                     .STICKY_MASK(MASK0), .HCW(HCW))
        u_dut0 (.clk(clk), .reset(reset), .bus(if0));

    pipe_stage_reg #(.DW(DW), .AW(AW), .TW(TW), .TNEW_DEC(1), .KEEP_PC_ON_BUBBLE(1'b0),
                     .STICKY_MASK('0), .HCW(HCW))
        u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    // Reference state; hold age kept as an unbounded integer and clipped on compare.
    typedef struct {
        bit            valid;
        logic [31:0]   pc;
        bit            bd;
        logic [AW-1:0] wr;
        bit            rw;
        int            tnew;
        logic [DW-1:0] payload;
        int            age;
    } mstate_t;

    mstate_t m [2];

    function automatic mstate_t model_next(input mstate_t s, input bit keep, input logic [DW-1:0] sticky);
        mstate_t n = s;
        if (reset || if0.req) begin
            n.valid = 0; n.bd = 0; n.wr = '0; n.rw = 0; n.tnew = 0; n.payload = '0; n.age = 0;
            n.pc = reset ? 32'h0000_3000 : 32'h0000_4180;
        end else if (if0.clr) begin
            n.valid = 0; n.wr = '0; n.rw = 0; n.tnew = 0; n.age = 0;
            n.payload = s.payload & sticky;
            n.pc = keep ? if0.d_pc : 32'h0000_3000;
            n.bd = keep ? if0.d_bd : 1'b0;
        end else if (!if0.en) begin
            n.age = s.valid ? s.age + 1 : 0;
        end else begin
            n.valid = if0.d_valid; n.pc = if0.d_pc; n.bd = if0.d_bd; n.wr = if0.d_wr;
            n.rw = if0.d_regwrite; n.tnew = int'(if0.d_tnew); n.payload = if0.d_payload; n.age = 0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic qv, input logic [31:0] qpc, input logic [31:0] qpc8,
                             input logic qbd, input logic [AW-1:0] qwr, input logic qrw,
                             input logic [TW-1:0] qtn, input logic [DW-1:0] qpl, input logic [HCW-1:0] qhc);
        bit eff_rw = m[k].valid && m[k].rw;
        int tn     = m[k].valid ? ((m[k].tnew - 1) < 0 ? 0 : m[k].tnew - 1) : 0;
        int hc     = m[k].age > 255 ? 255 : m[k].age;
        string p   = (k == 0) ? "d0" : "d1";
        chk({p, ".valid"},    128'(qv),   128'(m[k].valid));
        chk({p, ".pc"},       128'(qpc),  128'(m[k].pc));
        chk({p, ".pc8"},      128'(qpc8), 128'(32'(m[k].pc + 32'd8)));
        chk({p, ".bd"},       128'(qbd),  128'(m[k].bd));
        chk({p, ".wr"},       128'(qwr),  128'(eff_rw ? m[k].wr : 5'd0));
        chk({p, ".regwrite"}, 128'(qrw),  128'(eff_rw));
        chk({p, ".tnew"},     128'(qtn),  128'(tn));
        chk({p, ".payload"},  128'(qpl),  128'(m[k].payload));
        chk({p, ".hold_cnt"}, 128'(qhc),  128'(hc));
    endtask

    // One clock: advance the model on the edge, then compare both instances.
    task automatic cyc();
        @(posedge clk);
        m[0] = model_next(m[0], 1'b1, MASK0);
        m[1] = model_next(m[1], 1'b0, '0);
        #1;
        check_dut(0, if0.q_valid, if0.q_pc, if0.q_pc8, if0.q_bd, if0.q_wr, if0.q_regwrite,
                  if0.q_tnew, if0.q_payload, if0.q_hold_cnt);
        check_dut(1, if1.q_valid, if1.q_pc, if1.q_pc8, if1.q_bd, if1.q_wr, if1.q_regwrite,
                  if1.q_tnew, if1.q_payload, if1.q_hold_cnt);
    endtask

    task automatic drive(input bit en, input bit clr, input bit req, input bit v, input logic [31:0] pc,
                         input bit bd, input logic [AW-1:0] wr, input bit rw, input logic [TW-1:0] tn,
                         input logic [DW-1:0] pl);
        if0.en = en; if0.clr = clr; if0.req = req; if0.d_valid = v; if0.d_pc = pc; if0.d_bd = bd;
        if0.d_wr = wr; if0.d_regwrite = rw; if0.d_tnew = tn; if0.d_payload = pl;
    endtask

    logic [DW-1:0] pay;

    initial begin
        pay = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F005};
        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 0, '0, 0, '0, '0);
        cyc(); cyc();
        chk("reset.pc", 128'(if0.q_pc), 128'(32'h3000));
        chk("reset.pc8", 128'(if0.q_pc8), 128'(32'h3008));
        reset = 1'b0;

        drive(1, 0, 0, 1, 32'h3010, 0, 5'd8, 1, 3'd2, '0);
        cyc();
        chk("load.pc8", 128'(if0.q_pc8), 128'(32'h3018));
        chk("load.tnew", 128'(if0.q_tnew), 128'(3'd1));
        chk("load.wr", 128'(if0.q_wr), 128'(5'd8));

        drive(1, 0, 0, 1, 32'h3014, 0, 5'd8, 1, 3'd0, '0);
        cyc();
        chk("tnew.sat", 128'(if0.q_tnew), 128'(3'd0));

        drive(1, 0, 0, 1, 32'h3018, 0, 5'd5, 0, 3'd3, pay);
        cyc();
        chk("norw.wr", 128'(if0.q_wr), 128'(5'd0));
        chk("norw.rw", 128'(if0.q_regwrite), 128'(1'b0));

        drive(0, 0, 0, 1, 32'h3020, 1, 5'd9, 1, 3'd4, '0);
        for (int i = 1; i <= 300; i++) begin
            cyc();
            chk("hold.cnt", 128'(if0.q_hold_cnt), 128'(i > 255 ? 255 : i));
            chk("hold.pc", 128'(if0.q_pc), 128'(32'h3018));
        end
        drive(1, 0, 0, 1, 32'h3040, 0, 5'd3, 1, 3'd2, pay);
        cyc();
        chk("reload.cnt", 128'(if0.q_hold_cnt), 128'(0));
        chk("reload.pc", 128'(if0.q_pc), 128'(32'h3040));

        drive(0, 1, 0, 1, 32'h3024, 1, 5'd7, 1, 3'd2, '1);
        cyc();
        chk("clr.payload", 128'(if0.q_payload), 128'(96'h5));
        chk("clr.pc", 128'(if0.q_pc), 128'(32'h3024));
        chk("clr.bd", 128'(if0.q_bd), 128'(1'b1));
        chk("clr.valid", 128'(if0.q_valid), 128'(1'b0));
        chk("clr.nokeep.pc", 128'(if1.q_pc), 128'(32'h3000));
        chk("clr.nokeep.bd", 128'(if1.q_bd), 128'(1'b0));

        drive(1, 0, 0, 1, 32'h3050, 0, 5'd4, 1, 3'd1, pay);
        cyc();
        drive(0, 1, 1, 1, 32'h3054, 1, 5'd4, 1, 3'd1, pay);
        cyc();
        chk("req.pc", 128'(if0.q_pc), 128'(32'h4180));
        chk("req.payload", 128'(if0.q_payload), 128'(0));

        drive(1, 0, 0, 1, 32'h3060, 0, 5'd2, 1, 3'd1, pay);
        cyc();
        reset = 1'b1;
        drive(1, 0, 1, 1, 32'h3064, 0, 5'd2, 1, 3'd1, pay);
        cyc();
        chk("rstreq.pc", 128'(if0.q_pc), 128'(32'h3000));
        reset = 1'b0;

        drive(1, 0, 0, 1, 32'hFFFF_FFF8, 1, 5'd31, 1, 3'd7, pay);
        cyc();
        chk("pc8.wrap", 128'(if0.q_pc8), 128'(32'h0));

        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(99) < 2);
            drive($urandom_range(99) < 70, $urandom_range(99) < 10, $urandom_range(99) < 4,
                  1'($urandom), $urandom, 1'($urandom), 5'($urandom), 1'($urandom), 3'($urandom),
                  {$urandom, $urandom, $urandom});
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core. One instance is placed at each of the D/E, E/M and M/W boundaries.
- Replaces the hand-written per-stage registers with one block. It carries a valid bit, PC, branch-delay flag, write-register address, RegWrite and Tnew, plus an opaque control/data payload.
- Supports hold (stall), bubble insertion (clr), exception flush (req) and a per-stage stall-age counter.

Parameters:
- DW, 96: opaque payload width (operands, immediate, control fields).
- AW, 5: write-register address width.
- TW, 3: Tnew field width.
- TNEW_DEC, 1: amount subtracted from stored Tnew at the output, saturating at 0. Legal values 0..2.
- PC_RESET, 32'h0000_3000: PC loaded on reset.
- PC_REQ, 32'h0000_4180: PC loaded on exception flush.
- KEEP_PC_ON_BUBBLE, 1: 1 = a bubble keeps d_pc/d_bd (for precise EPC); 0 = a bubble loads PC_RESET and bd=0.
- STICKY_MASK, {DW{1'b0}}: payload bits set here hold their old value across a bubble (e.g. MDU op).
- HCW, 8: width of the hold counter.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high.
- en, in, 1: 1 = capture D side; 0 = hold contents.
- clr, in, 1: insert bubble (hazard stall).
- req, in, 1: exception/interrupt flush.
- d_valid, in, 1: incoming instruction is real.
- d_pc, in, 32: incoming PC.
- d_bd, in, 1: incoming instruction is in a delay slot.
- d_wr, in, AW: destination register.
- d_regwrite, in, 1: incoming instruction writes GRF.
- d_tnew, in, TW: incoming Tnew.
- d_payload, in, DW: opaque payload.
- q_valid, out, 1: stored instruction is real.
- q_pc, out, 32: stored PC.
- q_pc8, out, 32: q_pc + 8 (mod 2^32).
- q_bd, out, 1: stored delay-slot flag.
- q_wr, out, AW: effective destination register.
- q_regwrite, out, 1: effective write enable.
- q_tnew, out, TW: decremented Tnew.
- q_payload, out, DW: stored payload.
- q_hold_cnt, out, HCW: consecutive hold cycles of the current contents.

Behaviour:
- All state updates on posedge clk. Priority: reset > req > clr > en=0 (hold) > load.
- reset:
  - valid=0, pc=PC_RESET, bd=0, wr=0, regwrite=0, tnew=0, payload=0 (sticky bits included), hold_cnt=0.
  - Resulting outputs: q_valid=0, q_pc=0x3000, q_pc8=0x3008, q_wr=0, q_regwrite=0, q_tnew=0, q_payload=0, q_hold_cnt=0.
- req: same as reset except pc=PC_REQ. Sticky bits are also cleared. Overrides clr and en.
- clr (req=0): bubble.
  - valid=0, wr=0, regwrite=0, tnew=0.
  - Payload bits = STICKY_MASK ? old : 0.
  - pc/bd = d_pc/d_bd if KEEP_PC_ON_BUBBLE, else PC_RESET/0.
  - hold_cnt=0. Applies regardless of en.
- hold (en=0, clr=0, req=0): all fields unchanged. hold_cnt increments if valid=1 and saturates at 2^HCW-1; it stays 0 when valid=0.
- load (en=1, no clr/req): every field takes its d_ value; hold_cnt=0.
- Output gating (combinational from stored state):
  - q_regwrite = regwrite & valid.
  - q_wr = q_regwrite ? wr : 0.
  - q_tnew = valid ? (tnew >= TNEW_DEC ? tnew - TNEW_DEC : 0) : 0.
  - q_pc8 = pc + 32'd8, wrapping 0xFFFF_FFF8 to 0x0000_0000.
- Latency: one cycle from the D side to the Q side. There is no combinational path from d_* to q_*.
- Writes to $0 are not filtered here; the hazard unit ignores wr=0.

Test Plan:
- Reset, then load with d_valid=1, d_pc=0x3010, d_wr=8, d_regwrite=1, d_tnew=2 -> next cycle q_valid=1, q_pc=0x3010, q_pc8=0x3018, q_wr=8, q_regwrite=1, q_tnew=1.
- Load d_tnew=0 with TNEW_DEC=1 -> q_tnew=0 (saturate). Load d_regwrite=0, d_wr=5 -> q_wr=0, q_regwrite=0.
- Hold with en=0 for 300 cycles on a valid entry (HCW=8) -> contents stable, q_hold_cnt counts 1..255 and stays at 255. Then en=1 -> new data and q_hold_cnt=0.
- clr with en=0, d_pc=0x3024, d_bd=1, STICKY_MASK=0xF (payload bits 3:0 = 0x5, other payload bits nonzero) -> q_valid=0, q_pc=0x3024, q_bd=1, q_payload=0x5, q_tnew=0.
- Assert req and clr together while holding valid data -> q_pc=0x4180, q_valid=0, q_payload=0 (sticky cleared). Reset asserted in the same cycle as req -> q_pc=0x3000.
- Load d_pc=0xFFFF_FFF8 -> q_pc8=0x0000_0000. With KEEP_PC_ON_BUBBLE=0, a clr -> q_pc=0x3000, q_bd=0.
